// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between the victim cache and L2: absorbs evicted dirty lines,
// coalesces rewrites, serves read hits locally and drains to L2 in FIFO order.
module l2_writeback_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vc_read,
    input  logic              vc_write,
    input  logic [ADDR_W-1:0] vc_address,
    input  logic [LINE_W-1:0] vc_wdata,
    output logic [LINE_W-1:0] vc_rdata,
    output logic              vc_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = ADDR_W - 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [0:0] U_IDLE    = 1'b0;
    localparam logic [0:0] U_WAIT_L2 = 1'b1;
    localparam logic [1:0] L2_IDLE   = 2'd0;
    localparam logic [1:0] L2_WRITE  = 2'd1;
    localparam logic [1:0] L2_READ   = 2'd2;

    logic [DEPTH-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q, count_d;
    logic [0:0]        u_state_q, u_state_d;
    logic [1:0]        l2_state_q, l2_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0] vc_rdata_q, vc_rdata_d;
    logic              vc_resp_q, vc_resp_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [ADDR_W-1:0] l2_address_q, l2_address_d;
    logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
    logic              full_q, empty_q;

    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic              accept, launch_wr, head_busy;
    logic              enq, coalesce, pop;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tag_q[i] == vc_address[ADDR_W-1:4]) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign accept    = !vc_resp_q && (u_state_q == U_IDLE);
    assign launch_wr = (l2_state_q == L2_IDLE) && (u_state_q != U_WAIT_L2) && (count_q != '0);
    // The head counts as in flight on the launch cycle too, since l2_wdata samples it then.
    assign head_busy = (l2_state_q == L2_WRITE) || launch_wr;
    assign pop       = (l2_state_q == L2_WRITE) && l2_resp;

    always_comb begin
        enq          = 1'b0;
        coalesce     = 1'b0;
        u_state_d    = u_state_q;
        rd_addr_d    = rd_addr_q;
        vc_rdata_d   = vc_rdata_q;
        vc_resp_d    = 1'b0;
        l2_state_d   = l2_state_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        l2_address_d = l2_address_q;
        l2_wdata_d   = l2_wdata_q;

        if (accept) begin
            if (vc_write) begin
                if (hit) begin
                    if (!(hit_idx == head_q && head_busy)) begin
                        coalesce  = 1'b1;
                        vc_resp_d = 1'b1;
                    end
                end else if (count_q != FULL_CNT) begin
                    enq       = 1'b1;
                    vc_resp_d = 1'b1;
                end
            end else if (vc_read) begin
                if (hit) begin
                    vc_rdata_d = data_q[hit_idx];
                    vc_resp_d  = 1'b1;
                end else begin
                    u_state_d = U_WAIT_L2;
                    rd_addr_d = vc_address;
                end
            end
        end

        case (l2_state_q)
            L2_IDLE: begin
                if (u_state_q == U_WAIT_L2) begin
                    l2_state_d   = L2_READ;
                    l2_read_d    = 1'b1;
                    l2_address_d = rd_addr_q;
                end else if (count_q != '0) begin
                    l2_state_d   = L2_WRITE;
                    l2_write_d   = 1'b1;
                    l2_address_d = {tag_q[head_q], 4'b0000};
                    l2_wdata_d   = data_q[head_q];
                end
            end
            L2_WRITE: begin
                if (l2_resp) begin
                    l2_state_d = L2_IDLE;
                    l2_write_d = 1'b0;
                end
            end
            L2_READ: begin
                if (l2_resp) begin
                    l2_state_d = L2_IDLE;
                    l2_read_d  = 1'b0;
                    vc_rdata_d = l2_rdata;
                    vc_resp_d  = 1'b1;
                    u_state_d  = U_IDLE;
                end
            end
            default: l2_state_d = L2_IDLE;
        endcase

        count_d = count_q;
        if (enq && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!enq && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            u_state_q    <= U_IDLE;
            l2_state_q   <= L2_IDLE;
            rd_addr_q    <= '0;
            vc_rdata_q   <= '0;
            vc_resp_q    <= 1'b0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            count_q      <= count_d;
            u_state_q    <= u_state_d;
            l2_state_q   <= l2_state_d;
            rd_addr_q    <= rd_addr_d;
            vc_rdata_q   <= vc_rdata_d;
            vc_resp_q    <= vc_resp_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            l2_address_q <= l2_address_d;
            l2_wdata_q   <= l2_wdata_d;
            full_q       <= (count_d == FULL_CNT);
            empty_q      <= (count_d == '0);
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= vc_address[ADDR_W-1:4];
                data_q[tail_q]  <= vc_wdata;
                tail_q          <= tail_q + PW'(1);
            end
            if (coalesce) begin
                data_q[hit_idx] <= vc_wdata;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
        end
    end

    assign vc_rdata   = vc_rdata_q;
    assign vc_resp    = vc_resp_q;
    assign l2_read    = l2_read_q;
    assign l2_write   = l2_write_q;
    assign l2_address = l2_address_q;
    assign l2_wdata   = l2_wdata_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer: the bench plays both the victim cache and L2.
module tb_l2_writeback_buffer;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              vc_read = 1'b0;
    logic              vc_write = 1'b0;
    logic [ADDR_W-1:0] vc_address = '0;
    logic [LINE_W-1:0] vc_wdata = '0;
    logic [LINE_W-1:0] vc_rdata;
    logic              vc_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata = '0;
    logic              l2_resp = 1'b0;
    logic              full;
    logic              empty;

    int checks = 0;
    int failures = 0;

    localparam logic [LINE_W-1:0] D1 = {4{32'h1111_0001}};
    localparam logic [LINE_W-1:0] D2 = {4{32'h2222_0002}};
    localparam logic [LINE_W-1:0] D3 = {4{32'h3333_0003}};
    localparam logic [LINE_W-1:0] D4 = {4{32'h4444_0004}};
    localparam logic [LINE_W-1:0] R1 = {4{32'hA5A5_5A5A}};
    localparam logic [LINE_W-1:0] F1 = {4{32'hF1F1_0101}};
    localparam logic [LINE_W-1:0] F2 = {4{32'hF2F2_0202}};

    l2_writeback_buffer #(
        .DEPTH (4),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vc_read   (vc_read),
        .vc_write  (vc_write),
        .vc_address(vc_address),
        .vc_wdata  (vc_wdata),
        .vc_rdata  (vc_rdata),
        .vc_resp   (vc_resp),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_address(l2_address),
        .l2_wdata  (l2_wdata),
        .l2_rdata  (l2_rdata),
        .l2_resp   (l2_resp),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a write until vc_resp (bounded), then drop it and let vc_resp fall.
    task automatic vc_do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                               output int cyc);
        vc_write   = 1'b1;
        vc_address = a;
        vc_wdata   = d;
        cyc        = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (vc_resp) begin
                cyc = i;
                break;
            end
        end
        vc_write = 1'b0;
        tick();
    endtask

    // Wait (bounded) for an L2 write, capture it, then give one l2_resp pulse.
    task automatic l2_ack_write(output logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] d,
                                output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (l2_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        a = l2_address;
        d = l2_wdata;
        if (ok) begin
            l2_resp = 1'b1;
            tick();
            l2_resp = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (vc_resp !== 1'b0) begin failures++; $display("FAIL rst_vc_resp got=%0b exp=0", vc_resp); end
        checks++; if (vc_rdata !== '0) begin failures++; $display("FAIL rst_vc_rdata got=%h exp=0", vc_rdata); end
        checks++; if (l2_read !== 1'b0) begin failures++; $display("FAIL rst_l2_read got=%0b exp=0", l2_read); end
        checks++; if (l2_write !== 1'b0) begin failures++; $display("FAIL rst_l2_write got=%0b exp=0", l2_write); end
        checks++; if (l2_address !== '0) begin failures++; $display("FAIL rst_l2_address got=%h exp=0", l2_address); end
        checks++; if (l2_wdata !== '0) begin failures++; $display("FAIL rst_l2_wdata got=%h exp=0", l2_wdata); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", full); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_single_write();
        int cyc;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic ok;
        vc_do_write(16'h1230, D1, cyc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL t1_resp_latency got=%0d exp=1", cyc); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL t1_empty_after_wr got=%0b exp=0", empty); end
        checks++; if (l2_write !== 1'b1) begin failures++; $display("FAIL t1_l2_write got=%0b exp=1", l2_write); end
        l2_ack_write(a, d, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t1_l2_timeout got=%0b exp=1", ok); end
        checks++; if (a !== 16'h1230) begin failures++; $display("FAIL t1_l2_addr got=%h exp=1230", a); end
        checks++; if (d !== D1) begin failures++; $display("FAIL t1_l2_data got=%h exp=%h", d, D1); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL t1_empty_after_drain got=%0b exp=1", empty); end
    endtask

    task automatic test_full_stall();
        int cyc;
        logic stalled_resp;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic ok;
        logic [ADDR_W-1:0] exp_a [4];
        logic [LINE_W-1:0] exp_d [4];
        for (int i = 0; i < 4; i++) begin
            vc_do_write(16'h5000 + 16'(i * 16), {4{32'hE000_0000 + 32'(i)}}, cyc);
            checks++; if (cyc !== 1) begin failures++; $display("FAIL t2_wr%0d_latency got=%0d exp=1", i, cyc); end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL t2_full got=%0b exp=1", full); end
        vc_write     = 1'b1;
        vc_address   = 16'h5040;
        vc_wdata     = {4{32'hE000_0004}};
        stalled_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            stalled_resp |= vc_resp;
        end
        checks++; if (stalled_resp !== 1'b0) begin failures++; $display("FAIL t2_stall_resp got=%0b exp=0", stalled_resp); end
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        checks++; if (vc_resp !== 1'b0) begin failures++; $display("FAIL t2_pop_cycle_resp got=%0b exp=0", vc_resp); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL t2_full_after_pop got=%0b exp=0", full); end
        tick();
        checks++; if (vc_resp !== 1'b1) begin failures++; $display("FAIL t2_fifth_accept got=%0b exp=1", vc_resp); end
        vc_write = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 16'h5010 + 16'(i * 16);
            exp_d[i] = {4{32'hE000_0001 + 32'(i)}};
        end
        for (int i = 0; i < 4; i++) begin
            l2_ack_write(a, d, ok);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t2_drain%0d_timeout got=%0b exp=1", i, ok); end
            checks++; if (a !== exp_a[i]) begin failures++; $display("FAIL t2_drain%0d_addr got=%h exp=%h", i, a, exp_a[i]); end
            checks++; if (d !== exp_d[i]) begin failures++; $display("FAIL t2_drain%0d_data got=%h exp=%h", i, d, exp_d[i]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL t2_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_coalesce();
        int cyc;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic ok;
        vc_do_write(16'h2000, D1, cyc);
        vc_do_write(16'h2010, D2, cyc);
        vc_do_write(16'h2010, D3, cyc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL t3_coalesce_latency got=%0d exp=1", cyc); end
        l2_ack_write(a, d, ok);
        checks++; if (a !== 16'h2000 || d !== D1) begin failures++; $display("FAIL t3_first_drain got=%h/%h exp=2000/%h", a, d, D1); end
        l2_ack_write(a, d, ok);
        checks++; if (a !== 16'h2010 || d !== D3) begin failures++; $display("FAIL t3_second_drain got=%h/%h exp=2010/%h", a, d, D3); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL t3_empty_count2 got=%0b exp=1", empty); end
    endtask

    task automatic test_read();
        int cyc;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic ok;
        logic seen;
        vc_do_write(16'h3000, D4, cyc);
        vc_read    = 1'b1;
        vc_address = 16'h3000;
        tick();
        checks++; if (vc_resp !== 1'b1) begin failures++; $display("FAIL t4_hit_resp got=%0b exp=1", vc_resp); end
        checks++; if (vc_rdata !== D4) begin failures++; $display("FAIL t4_hit_data got=%h exp=%h", vc_rdata, D4); end
        checks++; if (l2_read !== 1'b0) begin failures++; $display("FAIL t4_hit_no_l2 got=%0b exp=0", l2_read); end
        vc_read = 1'b0;
        tick();
        vc_read    = 1'b1;
        vc_address = 16'h4000;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (l2_read !== 1'b0) begin failures++; $display("FAIL t4_read_waits_drain got=%0b exp=0", l2_read); end
        l2_ack_write(a, d, ok);
        checks++; if (a !== 16'h3000) begin failures++; $display("FAIL t4_drain_addr got=%h exp=3000", a); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (l2_read) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL t4_l2_read_timeout got=%0b exp=1", seen); end
        checks++; if (l2_address !== 16'h4000) begin failures++; $display("FAIL t4_l2_read_addr got=%h exp=4000", l2_address); end
        l2_rdata = R1;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
        l2_rdata = '0;
        checks++; if (vc_resp !== 1'b1) begin failures++; $display("FAIL t4_miss_resp got=%0b exp=1", vc_resp); end
        checks++; if (vc_rdata !== R1) begin failures++; $display("FAIL t4_miss_data got=%h exp=%h", vc_rdata, R1); end
        vc_read = 1'b0;
        tick();
        checks++; if (vc_resp !== 1'b0 || l2_read !== 1'b0) begin failures++; $display("FAIL t4_idle_after got=%0b/%0b exp=0/0", vc_resp, l2_read); end
    endtask

    task automatic test_inflight_write();
        int cyc;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic ok;
        logic stalled_resp;
        vc_do_write(16'h6000, F1, cyc);
        vc_write     = 1'b1;
        vc_address   = 16'h6000;
        vc_wdata     = F2;
        stalled_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            stalled_resp |= vc_resp;
        end
        checks++; if (stalled_resp !== 1'b0) begin failures++; $display("FAIL t5_stall got=%0b exp=0", stalled_resp); end
        l2_ack_write(a, d, ok);
        checks++; if (a !== 16'h6000 || d !== F1) begin failures++; $display("FAIL t5_old_drain got=%h/%h exp=6000/%h", a, d, F1); end
        cyc = -1;
        for (int i = 1; i <= 10; i++) begin
            if (vc_resp) begin
                cyc = i;
                break;
            end
            tick();
        end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL t5_accept_after_pop got=%0d exp=2", cyc); end
        vc_write = 1'b0;
        tick();
        l2_ack_write(a, d, ok);
        checks++; if (a !== 16'h6000 || d !== F2) begin failures++; $display("FAIL t5_new_drain got=%h/%h exp=6000/%h", a, d, F2); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL t5_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        logic any_write;
        vc_do_write(16'h7000, D1, cyc);
        vc_do_write(16'h7010, D2, cyc);
        checks++; if (l2_write !== 1'b1) begin failures++; $display("FAIL t6_pre_l2_write got=%0b exp=1", l2_write); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (l2_write !== 1'b0) begin failures++; $display("FAIL t6_l2_write got=%0b exp=0", l2_write); end
        checks++; if (l2_address !== '0 || l2_wdata !== '0) begin failures++; $display("FAIL t6_l2_bus got=%h/%h exp=0/0", l2_address, l2_wdata); end
        checks++; if (vc_rdata !== '0) begin failures++; $display("FAIL t6_vc_rdata got=%h exp=0", vc_rdata); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL t6_flags got=%0b/%0b exp=1/0", empty, full); end
        tick();
        reset_n   = 1'b1;
        any_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_write |= l2_write;
        end
        checks++; if (any_write !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL t6_data_lost got=%0b/%0b exp=0/1", any_write, empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_single_write();
        test_full_stall();
        test_coalesce();
        test_read();
        test_inflight_write();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
